// File: rtl/mem_pkg.sv
// Shared state encoding, default parameters and counter helpers for the memory
// sequencer and its wait counter.
package mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT_WR   = 3'd1,
        S_INIT_HOLD = 3'd2,
        S_RD_WAIT   = 3'd3,
        S_LOAD      = 3'd4,
        S_PROC_WAIT = 3'd5,
        S_WB_WR     = 3'd6
    } state_e;

    localparam int DEF_DATA_W   = 48;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_RD_LAT   = 7;
    localparam int DEF_WR_CYC   = 7;
    localparam int DEF_HOLD_CYC = 7;
    localparam int CNT_W        = 8;

    // A state lasting 'cycles' cycles ends when the counter reads cycles-1.
    function automatic logic [CNT_W-1:0] term_of(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/mem_sequencer_wait_counter.sv
// Shared cycle counter: clears on request, counts while enabled and flags
// when it has reached the terminal value.
module wait_counter
    import mem_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear has priority over counting.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {W{1'b0}};
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = en_i && (count_q == term_i);

endmodule

// File: rtl/mem_sequencer.sv
// Memory sequencer: fills memory on request, reads bursts into the datapath
// registers and writes the processed burst back to the same addresses.
module mem_sequencer
    import mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int WR_CYC   = DEF_WR_CYC,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_req,
    input  logic              load_req,
    input  logic              abort,
    input  logic              proc_done,
    input  logic [ADDR_W-1:0] addr_base,
    input  logic [ADDR_W-1:0] burst_len,
    input  logic [DATA_W-1:0] init_data,
    input  logic [DATA_W-1:0] datapath_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              load_registers,
    output logic [ADDR_W-1:0] word_idx,
    output logic              ready,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  RD_TERM   = term_of(RD_LAT);
    localparam logic [CNT_W-1:0]  WR_TERM   = term_of(WR_CYC);
    localparam logic [CNT_W-1:0]  HOLD_TERM = term_of(HOLD_CYC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] addr_base_q, addr_base_d;
    logic [ADDR_W-1:0] burst_len_q, burst_len_d;
    logic              cnt_clr_s, cnt_en_s, cnt_done_s;
    logic [CNT_W-1:0]  cnt_term_s;

    wait_counter #(.W(CNT_W)) u_wait_counter (
        .clock  (clock),
        .reset  (reset),
        .clr_i  (cnt_clr_s),
        .en_i   (cnt_en_s),
        .term_i (cnt_term_s),
        .done_o (cnt_done_s)
    );

    // Next-state, word index and counter control. Untimed states hold the
    // counter clear; timed states clear it on every word advance or exit.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        addr_base_d = addr_base_q;
        burst_len_d = burst_len_q;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        cnt_term_s  = {CNT_W{1'b0}};
        case (state_q)
            S_IDLE: begin
                cnt_clr_s = 1'b1;
                if (init_req) begin
                    state_d    = S_INIT_WR;
                    word_idx_d = IDX_ZERO;
                end else if (load_req) begin
                    state_d     = S_RD_WAIT;
                    word_idx_d  = IDX_ZERO;
                    addr_base_d = addr_base;
                    burst_len_d = burst_len;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT_WR: begin
                cnt_en_s   = 1'b1;
                cnt_term_s = WR_TERM;
                if (cnt_done_s) begin
                    cnt_clr_s = 1'b1;
                    if (word_idx_q == LAST_IDX) begin
                        state_d    = S_INIT_HOLD;
                        word_idx_d = IDX_ZERO;
                    end else begin
                        word_idx_d = word_idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            S_INIT_HOLD: begin
                cnt_en_s   = 1'b1;
                cnt_term_s = HOLD_TERM;
                if (cnt_done_s) begin
                    cnt_clr_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            S_RD_WAIT: begin
                cnt_en_s   = 1'b1;
                cnt_term_s = RD_TERM;
                if (cnt_done_s) begin
                    cnt_clr_s = 1'b1;
                    state_d   = S_LOAD;
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            S_LOAD: begin
                cnt_clr_s = 1'b1;
                if (word_idx_q < burst_len_q) begin
                    state_d    = S_RD_WAIT;
                    word_idx_d = word_idx_q + IDX_ONE;
                end else begin
                    state_d    = S_PROC_WAIT;
                    word_idx_d = IDX_ZERO;
                end
            end
            S_PROC_WAIT: begin
                cnt_clr_s = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (proc_done) begin
                    state_d = S_WB_WR;
                end else begin
                    state_d = S_PROC_WAIT;
                end
            end
            S_WB_WR: begin
                cnt_en_s   = 1'b1;
                cnt_term_s = WR_TERM;
                if (cnt_done_s) begin
                    cnt_clr_s = 1'b1;
                    if (word_idx_q == burst_len_q) begin
                        state_d    = S_IDLE;
                        word_idx_d = IDX_ZERO;
                    end else begin
                        word_idx_d = word_idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_clr_s = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                word_idx_d = IDX_ZERO;
                cnt_clr_s  = 1'b1;
            end
        endcase
    end

    // State and burst context registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            word_idx_q  <= IDX_ZERO;
            addr_base_q <= IDX_ZERO;
            burst_len_q <= IDX_ZERO;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            addr_base_q <= addr_base_d;
            burst_len_q <= burst_len_d;
        end
    end

    // Outputs decode only registered state, so reset clears them at once.
    always_comb begin
        mem_addr       = addr_base_q + word_idx_q;
        mem_wdata      = datapath_out;
        mem_we         = 1'b0;
        load_registers = 1'b0;
        ready          = 1'b0;
        init_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_addr  = IDX_ZERO;
                mem_wdata = init_data;
                ready     = 1'b1;
            end
            S_INIT_WR: begin
                mem_addr  = word_idx_q;
                mem_wdata = init_data;
                mem_we    = 1'b1;
            end
            S_INIT_HOLD: begin
                mem_addr  = word_idx_q;
                mem_wdata = init_data;
                init_done = 1'b1;
            end
            S_LOAD:  load_registers = 1'b1;
            S_WB_WR: mem_we         = 1'b1;
            default: mem_we         = 1'b0;
        endcase
    end

    assign word_idx = word_idx_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed scoreboard bench for mem_sequencer: expected writes and read strobes
// are queued as stimulus is driven and compared by negedge monitors.
module tb_mem_sequencer;

    localparam int DW = 48;
    localparam int AW = 4;
    localparam int LAT = 7;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [AW-1:0] addr; logic [AW-1:0] idx; } rd_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          init_req = 1'b0, load_req = 1'b0, abort = 1'b0, proc_done = 1'b0;
    logic [AW-1:0] addr_base = '0, burst_len = '0;
    logic [DW-1:0] init_data = '0, datapath_out = '0;
    logic [AW-1:0] mem_addr, word_idx;
    logic [DW-1:0] mem_wdata;
    logic          mem_we, load_registers, ready, init_done;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    bit  wr_ignore = 1'b0;
    int  hold_events = 0;

    mem_sequencer dut (
        .clock(clock), .reset(reset), .init_req(init_req), .load_req(load_req),
        .abort(abort), .proc_done(proc_done), .addr_base(addr_base),
        .burst_len(burst_len), .init_data(init_data), .datapath_out(datapath_out),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .load_registers(load_registers), .word_idx(word_idx), .ready(ready),
        .init_done(init_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (ready !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(ready), 64'(1));
    endtask

    task automatic wait_reads(input string tag, input int budget);
        int n = 0;
        while (exp_rd.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 64'(exp_rd.size()), 64'(0));
    endtask

    task automatic push_reads(input logic [AW-1:0] base, input int len);
        for (int i = 0; i <= len; i++) begin
            rd_t r;
            r.addr = base + AW'(i);
            r.idx  = AW'(i);
            exp_rd.push_back(r);
        end
    endtask

    task automatic push_writes(input logic [AW-1:0] base, input int len, input logic [DW-1:0] d);
        for (int i = 0; i <= len; i++) begin
            wr_t w;
            w.addr = base + AW'(i);
            w.data = d;
            exp_wr.push_back(w);
        end
    endtask

    // Write monitor: groups contiguous mem_we cycles per address into one word.
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    int            wr_len = 0;
    bit            in_wr = 1'b0;

    task automatic close_write();
        wr_t e;
        if (exp_wr.size() == 0) begin
            check("wr_unexpected", 64'(cur_addr), 64'hFFFF);
        end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 64'(cur_addr), 64'(e.addr));
            check("wr_data", 64'(cur_data), 64'(e.data));
            check("wr_len", 64'(wr_len), 64'(LAT));
        end
    endtask

    always @(negedge clock) begin
        if (reset || wr_ignore) begin
            in_wr  = 1'b0;
            wr_len = 0;
        end else if (mem_we === 1'b1) begin
            if (in_wr && mem_addr === cur_addr && mem_wdata === cur_data) begin
                wr_len++;
            end else begin
                if (in_wr) close_write();
                cur_addr = mem_addr;
                cur_data = mem_wdata;
                wr_len   = 1;
                in_wr    = 1'b1;
            end
        end else if (in_wr) begin
            close_write();
            in_wr = 1'b0;
        end
    end

    // Read monitor: a strobe must match the next queued word and arrive RD_LAT
    // cycles after its address first appeared.
    logic [AW-1:0] prev_addr = '0;
    int            addr_age = 0;
    always @(negedge clock) begin
        rd_t r;
        if (!reset) begin
            if (mem_addr !== prev_addr) addr_age = 0;
            else addr_age++;
            prev_addr = mem_addr;
            if (load_registers === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", 64'(mem_addr), 64'hFFFF);
                end else begin
                    r = exp_rd.pop_front();
                    check("rd_addr", 64'(mem_addr), 64'(r.addr));
                    check("rd_idx", 64'(word_idx), 64'(r.idx));
                    check("rd_latency", 64'(addr_age), 64'(LAT));
                end
            end
        end
    end

    // init_done monitor: each high pulse lasts HOLD_CYC cycles and hands over to ready.
    int hold_cnt = 0;
    always @(negedge clock) begin
        if (reset) begin
            hold_cnt = 0;
        end else if (init_done === 1'b1) begin
            hold_cnt++;
        end else if (hold_cnt != 0) begin
            check("init_hold_len", 64'(hold_cnt), 64'(LAT));
            check("ready_after_hold", 64'(ready), 64'(1));
            hold_events++;
            hold_cnt = 0;
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_we", 64'(mem_we), 64'(0));
        check("rst_load", 64'(load_registers), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_idx", 64'(word_idx), 64'(0));
        reset = 1'b0;
        step();

        // Full initialisation
        init_data = 48'hA5A5;
        push_writes(4'd0, 15, init_data);
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        wait_ready("init_ready", 300);
        @(negedge clock); #1;
        check("init_writes_left", 64'(exp_wr.size()), 64'(0));
        check("init_hold_events", 64'(hold_events), 64'(1));

        // init_req wins over a simultaneous load_req
        init_data = 48'h0000_5A5A_0001;
        push_writes(4'd0, 15, init_data);
        init_req  = 1'b1;
        load_req  = 1'b1;
        addr_base = 4'd2;
        burst_len = 4'd1;
        step();
        init_req = 1'b0;
        load_req = 1'b0;
        wait_ready("both_ready", 300);
        @(negedge clock); #1;
        check("both_writes_left", 64'(exp_wr.size()), 64'(0));
        check("both_hold_events", 64'(hold_events), 64'(2));
        repeat (5) step();
        check("both_no_load", 64'(ready), 64'(1));

        // proc_done outside PROC_WAIT is ignored
        proc_done = 1'b1;
        step();
        proc_done = 1'b0;
        step();
        check("idle_ignore_ready", 64'(ready), 64'(1));
        check("idle_ignore_we", 64'(mem_we), 64'(0));

        // Wrapping burst 14,15,0,1 then write-back
        push_reads(4'd14, 3);
        addr_base = 4'd14;
        burst_len = 4'd3;
        load_req  = 1'b1;
        step();
        load_req  = 1'b0;
        addr_base = 4'd7;
        burst_len = 4'd0;
        wait_reads("burst_reads", 200);
        check("proc_wait_ready", 64'(ready), 64'(0));
        check("proc_wait_idx", 64'(word_idx), 64'(0));
        datapath_out = 48'h1234;
        push_writes(4'd14, 3, datapath_out);
        proc_done = 1'b1;
        step();
        proc_done = 1'b0;
        wait_ready("wb_ready", 200);
        @(negedge clock); #1;
        check("wb_writes_left", 64'(exp_wr.size()), 64'(0));

        // Full-depth burst touches every word exactly once
        push_reads(4'd9, 15);
        addr_base = 4'd9;
        burst_len = 4'd15;
        load_req  = 1'b1;
        step();
        load_req = 1'b0;
        wait_reads("full_reads", 400);
        datapath_out = 48'hBEEF_0000_CAFE;
        push_writes(4'd9, 15, datapath_out);
        proc_done = 1'b1;
        step();
        proc_done = 1'b0;
        wait_ready("full_ready", 400);
        @(negedge clock); #1;
        check("full_writes_left", 64'(exp_wr.size()), 64'(0));

        // abort beats proc_done in PROC_WAIT
        push_reads(4'd3, 0);
        addr_base = 4'd3;
        burst_len = 4'd0;
        load_req  = 1'b1;
        step();
        load_req = 1'b0;
        wait_reads("abort_reads", 100);
        abort     = 1'b1;
        proc_done = 1'b1;
        step();
        abort     = 1'b0;
        proc_done = 1'b0;
        check("abort_ready", 64'(ready), 64'(1));
        check("abort_we", 64'(mem_we), 64'(0));
        repeat (LAT + 2) step();
        check("abort_no_write", 64'(exp_wr.size()), 64'(0));

        // Reset in the third cycle of a write-back word
        push_reads(4'd5, 1);
        addr_base = 4'd5;
        burst_len = 4'd1;
        load_req  = 1'b1;
        step();
        load_req = 1'b0;
        wait_reads("rst_reads", 100);
        datapath_out = 48'h7777;
        wr_ignore    = 1'b1;
        proc_done    = 1'b1;
        step();
        proc_done = 1'b0;
        check("wb1_we", 64'(mem_we), 64'(1));
        check("wb1_addr", 64'(mem_addr), 64'(5));
        check("wb1_wdata", 64'(mem_wdata), 64'(48'h7777));
        step();
        step();
        #2 reset = 1'b1;
        #1;
        check("async_we", 64'(mem_we), 64'(0));
        check("async_ready", 64'(ready), 64'(1));
        check("async_addr", 64'(mem_addr), 64'(0));
        check("async_idx", 64'(word_idx), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        step();
        check("post_rst_ready", 64'(ready), 64'(1));
        check("post_rst_we", 64'(mem_we), 64'(0));
        wr_ignore = 1'b0;
        step();

        check("final_rd_left", 64'(exp_rd.size()), 64'(0));
        check("final_hold_events", 64'(hold_events), 64'(2));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter DATA_W, default 48: memory word width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; depth = 2^ADDR_W words.
REQ-003 Parameter RD_LAT, default 7: cycles from address presentation to valid read data.
REQ-004 Parameter WR_CYC, default 7: cycles mem_we is held per written word.
REQ-005 Parameter HOLD_CYC, default 7: cycles init_done is held high after initialisation.
REQ-006 Port clock  in  1: single clock; all state changes on its rising edge.
REQ-007 Port reset  in  1: one clock; reset is asynchronous and active-high.
REQ-008 Port init_req  in  1: request to fill the whole memory with init_data.
REQ-009 Port load_req  in  1: request to start a read burst.
REQ-010 Port abort  in  1: cancel pending write-back while waiting for the datapath.
REQ-011 Port proc_done  in  1: datapath finished; start write-back.
REQ-012 Port addr_base  in  ADDR_W: burst start address, sampled on load_req acceptance.
REQ-013 Port burst_len  in  ADDR_W: words in burst minus one, sampled on load_req acceptance.
REQ-014 Port init_data  in  DATA_W: fill word for initialisation.
REQ-015 Port datapath_out  in  DATA_W: write-back data for the current word_idx.
REQ-016 Port mem_addr  out  ADDR_W: memory address.
REQ-017 Port mem_wdata  out  DATA_W: memory write data.
REQ-018 Port mem_we  out  1: memory write enable.
REQ-019 Port load_registers  out  1: one-cycle strobe; read data is valid for word_idx.
REQ-020 Port word_idx  out  ADDR_W: index of current word within burst/fill.
REQ-021 Port ready  out  1: high only in IDLE; requests accepted only then.
REQ-022 Port init_done  out  1: high throughout INIT_HOLD.

Function
REQ-023 The FSM SHALL have states IDLE, INIT_WR, INIT_HOLD, RD_WAIT, LOAD, PROC_WAIT, WB_WR.
REQ-024 IDLE SHALL go to INIT_WR on init_req, else to RD_WAIT on load_req; init_req wins when both are high.
REQ-025 INIT_WR SHALL write init_data to addresses 0..2^ADDR_W-1 in order, each with mem_we high for WR_CYC cycles; after the last word it goes to INIT_HOLD.
REQ-026 INIT_HOLD SHALL last HOLD_CYC cycles with init_done=1, then go to IDLE.
REQ-027 RD_WAIT SHALL present mem_addr = addr_base+word_idx (mod 2^ADDR_W) for RD_LAT cycles, then go to LOAD.
REQ-028 LOAD SHALL last one cycle with load_registers=1; it returns to RD_WAIT with word_idx+1 if word_idx<burst_len, else goes to PROC_WAIT with word_idx=0.
REQ-029 PROC_WAIT SHALL go to WB_WR on proc_done, or to IDLE on abort (no writes); abort wins when both are high.
REQ-030 WB_WR SHALL drive mem_wdata=datapath_out and mem_addr=addr_base+word_idx with mem_we=1 for WR_CYC cycles per word, iterate word_idx 0..burst_len, then go to IDLE.
REQ-031 Address arithmetic SHALL wrap modulo 2^ADDR_W; burst_len=2^ADDR_W-1 SHALL access every word exactly once.
REQ-032 Requests, proc_done and abort SHALL be ignored in states where they are not listed.
REQ-033 Wait counters SHALL reset to 0 on every state entry and every word advance.
REQ-034 mem_wdata SHALL equal init_data in IDLE/INIT states and datapath_out otherwise.

Reset
REQ-035 Asserting reset SHALL immediately force IDLE, with counters and word_idx at 0, mem_we=0, load_registers=0, init_done=0, ready=1, mem_addr=0, and latched addr_base/burst_len at 0.
REQ-036 Reset asserted mid-write SHALL drop mem_we in the same cycle without waiting for a clock edge.

Structure
REQ-037 State encodings and default parameter values SHALL live in the shared package mem_pkg.
REQ-038 A single sub-module, wait_counter (load/enable/terminal-count compare), SHALL be instantiated once and shared by all timed states.

Verification
REQ-039 After reset, pulse init_req with init_data=48'hA5A5 -> 16 words written at addresses 0..15, each with mem_we high for 7 cycles, then init_done high for 7 cycles, then ready=1.
REQ-040 load_req with addr_base=14, burst_len=3 -> reads at addresses 14,15,0,1, each load_registers strobe 7 cycles after its address, and word_idx 0..3 at the strobes.
REQ-041 After a burst, proc_done with datapath_out=48'h1234 -> writes to addresses 14,15,0,1, then ready=1.
REQ-042 In PROC_WAIT, assert abort and proc_done in the same cycle -> no mem_we, IDLE next cycle.
REQ-043 init_req and load_req high together in IDLE -> init sequence runs and load_req is ignored.
REQ-044 Assert reset during the 3rd cycle of a WB_WR word -> mem_we=0 asynchronously; after release, IDLE with ready=1.
